// File: rtl/eth_rx_block_lock_pkg.sv
// Shared encodings and constants for the 64b/66b receive block-lock framer.
package eth_rx_block_lock_pkg;

  typedef enum logic [2:0] {
    ST_HUNT      = 3'd0,
    ST_SLIP      = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RESET_REQ = 3'd3,
    ST_LOCKED    = 3'd4
  } state_e;

  localparam logic [1:0] SYNC_DATA     = 2'b01;
  localparam logic [1:0] SYNC_CTRL     = 2'b10;
  localparam int         LOCK_WINDOW   = 64;
  localparam int         BAD_HDR_LIMIT = 16;

  function automatic logic is_sync_valid(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_rx_block_lock.sv
// 64b/66b block-lock framer: hunts for 64 good sync headers, slips the gearbox
// on errors, and requests an RX datapath reset after too many fruitless slips.
module eth_rx_block_lock
  import eth_rx_block_lock_pkg::*;
#(
  parameter int HDR_WIDTH           = 2,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8,
  parameter int SLIP_LIMIT          = 132,
  parameter int RESET_REQ_CYCLES    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
  input  logic                 serdes_rx_hdr_valid,
  output logic                 serdes_rx_bitslip,
  output logic                 serdes_rx_reset_req,
  output logic                 rx_block_lock,
  output logic                 rx_bad_hdr
);

  localparam int TMR_MAX =
    (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES)
      ? ((BITSLIP_HIGH_CYCLES > RESET_REQ_CYCLES) ? BITSLIP_HIGH_CYCLES : RESET_REQ_CYCLES)
      : ((BITSLIP_LOW_CYCLES  > RESET_REQ_CYCLES) ? BITSLIP_LOW_CYCLES  : RESET_REQ_CYCLES);
  localparam int TMR_W  = $clog2(TMR_MAX + 1);
  localparam int SLIP_W = $clog2(SLIP_LIMIT + 1);

  localparam logic [TMR_W-1:0]  TMR_HIGH  = TMR_W'(BITSLIP_HIGH_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_LOW   = TMR_W'(BITSLIP_LOW_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_RREQ  = TMR_W'(RESET_REQ_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
  localparam logic [SLIP_W-1:0] SLIP_MAX  = SLIP_W'(SLIP_LIMIT);
  localparam logic [SLIP_W-1:0] SLIP_ONE  = SLIP_W'(1);
  localparam logic [5:0]        SH_LAST   = 6'(LOCK_WINDOW - 1);
  localparam logic [4:0]        BAD_LAST  = 5'(BAD_HDR_LIMIT - 1);

  state_e             r_state,     w_state_nxt;
  logic [5:0]         r_sh_cnt,    w_sh_cnt_nxt;
  logic [4:0]         r_bad_cnt,   w_bad_cnt_nxt;
  logic [SLIP_W-1:0]  r_slip_cnt,  w_slip_cnt_nxt;
  logic [TMR_W-1:0]   r_tmr,       w_tmr_nxt;
  logic               w_bad_hdr_nxt;
  logic               r_bitslip, r_reset_req, r_block_lock, r_bad_hdr;

  logic w_hdr_good;
  logic w_hdr_bad;

  assign w_hdr_good = serdes_rx_hdr_valid &&  is_sync_valid(serdes_rx_hdr);
  assign w_hdr_bad  = serdes_rx_hdr_valid && !is_sync_valid(serdes_rx_hdr);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
    w_state_nxt    = r_state;
    w_sh_cnt_nxt   = r_sh_cnt;
    w_bad_cnt_nxt  = r_bad_cnt;
    w_slip_cnt_nxt = r_slip_cnt;
    w_tmr_nxt      = r_tmr;
    w_bad_hdr_nxt  = 1'b0;

    case (r_state)
      ST_HUNT: begin
        if (w_hdr_good) begin
          if (r_sh_cnt == SH_LAST) begin
            w_state_nxt    = ST_LOCKED;
            w_sh_cnt_nxt   = '0;
            w_slip_cnt_nxt = '0;
          end else begin
            w_sh_cnt_nxt = r_sh_cnt + 6'd1;
          end
        end else if (w_hdr_bad) begin
          w_state_nxt    = ST_SLIP;
          w_sh_cnt_nxt   = '0;
          w_slip_cnt_nxt = r_slip_cnt + SLIP_ONE;
          w_tmr_nxt      = TMR_HIGH;
        end
      end

      ST_SLIP: begin
        if (r_tmr == '0) begin
          w_state_nxt = ST_SETTLE;
          w_tmr_nxt   = TMR_LOW;
        end else begin
          w_tmr_nxt = r_tmr - TMR_ONE;
        end
      end

      // Headers are deliberately ignored while the gearbox output settles.
      ST_SETTLE: begin
        if (r_tmr != '0) begin
          w_tmr_nxt = r_tmr - TMR_ONE;
        end else if (r_slip_cnt == SLIP_MAX) begin
          w_state_nxt = ST_RESET_REQ;
          w_tmr_nxt   = TMR_RREQ;
        end else begin
          w_state_nxt = ST_HUNT;
        end
      end

      ST_RESET_REQ: begin
        if (r_tmr == '0) begin
          w_state_nxt    = ST_HUNT;
          w_slip_cnt_nxt = '0;
        end else begin
          w_tmr_nxt = r_tmr - TMR_ONE;
        end
      end

      ST_LOCKED: begin
        if (serdes_rx_hdr_valid) begin
          w_bad_hdr_nxt = w_hdr_bad;
          // Losing lock takes priority over the window rollover on the same header.
          if (w_hdr_bad && (r_bad_cnt == BAD_LAST)) begin
            w_state_nxt    = ST_SLIP;
            w_sh_cnt_nxt   = '0;
            w_bad_cnt_nxt  = '0;
            w_slip_cnt_nxt = r_slip_cnt + SLIP_ONE;
            w_tmr_nxt      = TMR_HIGH;
          end else if (r_sh_cnt == SH_LAST) begin
            w_sh_cnt_nxt  = '0;
            w_bad_cnt_nxt = '0;
          end else begin
            w_sh_cnt_nxt = r_sh_cnt + 6'd1;
            if (w_hdr_bad) w_bad_cnt_nxt = r_bad_cnt + 5'd1;
          end
        end
      end

      default: w_state_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_state      <= ST_HUNT;
      r_sh_cnt     <= '0;
      r_bad_cnt    <= '0;
      r_slip_cnt   <= '0;
      r_tmr        <= '0;
      r_bitslip    <= 1'b0;
      r_reset_req  <= 1'b0;
      r_block_lock <= 1'b0;
      r_bad_hdr    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sh_cnt     <= w_sh_cnt_nxt;
      r_bad_cnt    <= w_bad_cnt_nxt;
      r_slip_cnt   <= w_slip_cnt_nxt;
      r_tmr        <= w_tmr_nxt;
      r_bitslip    <= (w_state_nxt == ST_SLIP);
      r_reset_req  <= (w_state_nxt == ST_RESET_REQ);
      r_block_lock <= (w_state_nxt == ST_LOCKED);
      r_bad_hdr    <= w_bad_hdr_nxt;
    end
  end

  assign serdes_rx_bitslip   = r_bitslip;
  assign serdes_rx_reset_req = r_reset_req;
  assign rx_block_lock       = r_block_lock;
  assign rx_bad_hdr          = r_bad_hdr;

endmodule
